// File: rtl/pipe_ctrl_chain.sv
// Elastic valid/ready pipeline-register chain with per-stage hold/flush and a saturating stall counter.
// Define PIPE_SKID_BUFFER_EN to add a one-entry skid register that breaks the Out_Ready -> In_Ready path.
module pipe_ctrl_chain #(
    parameter int DATA_W = 32,
    parameter int STAGES = 5,
    parameter int CNT_W  = 16
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          In_Valid,
    input  logic [DATA_W-1:0]             In_Data,
    output logic                          In_Ready,
    output logic                          Out_Valid,
    output logic [DATA_W-1:0]             Out_Data,
    input  logic                          Out_Ready,
    input  logic [STAGES-1:0]             Hold,
    input  logic [STAGES-1:0]             Flush,
    output logic [STAGES-1:0]             StageValid,
    output logic [STAGES*DATA_W-1:0]      StageData,
    output logic [$clog2(STAGES+2)-1:0]   Occupancy,
    output logic [CNT_W-1:0]              StallCount
);

    localparam int LAST  = STAGES - 1;
    localparam int OCC_W = $clog2(STAGES + 2);

    logic [STAGES-1:0] stageVld;
    logic [DATA_W-1:0] stageReg [STAGES];
    logic [DATA_W-1:0] loadData [STAGES];
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              sinkRdy;
    logic [CNT_W-1:0]  stallCnt;

`ifdef PIPE_SKID_BUFFER_EN
    logic              skidVld;
    logic [DATA_W-1:0] skidReg;

    // Skid readiness is registered, so the downstream ready never reaches the advance chain.
    assign sinkRdy   = !skidVld;
    assign Out_Valid = skidVld || stageVld[LAST];
    assign Out_Data  = skidVld ? skidReg : stageReg[LAST];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            skidVld <= 1'b0;
            skidReg <= '0;
        end else if (skidVld) begin
            if (Out_Ready) skidVld <= 1'b0;
        end else if (adv[LAST] && !Out_Ready) begin
            skidVld <= 1'b1;
            skidReg <= stageReg[LAST];
        end
    end
`else
    assign sinkRdy   = Out_Ready;
    assign Out_Valid = stageVld[LAST];
    assign Out_Data  = stageReg[LAST];
`endif

    // Ready ripples from the sink toward stage 0; Flush is deliberately kept out of this chain.
    always_comb begin
        logic downRdy;
        logic stepAdv;
        adv     = '0;
        downRdy = sinkRdy;
        for (int i = LAST; i >= 0; i--) begin
            stepAdv = stageVld[i] && !Hold[i] && downRdy;
            adv[i]  = stepAdv;
            downRdy = !stageVld[i] || stepAdv;
        end
        In_Ready = downRdy;
    end

    assign load = {adv[STAGES-2:0], In_Valid && In_Ready};

    always_comb begin
        loadData[0] = In_Data;
        for (int i = 1; i < STAGES; i++) loadData[i] = stageReg[i-1];
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            stageVld <= '0;
            for (int i = 0; i < STAGES; i++) stageReg[i] <= '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (Flush[i])     stageVld[i] <= 1'b0;
                else if (load[i]) stageVld[i] <= 1'b1;
                else if (adv[i])  stageVld[i] <= 1'b0;
                if (load[i] && !Flush[i]) stageReg[i] <= loadData[i];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            stallCnt <= '0;
        else if (In_Valid && !In_Ready && stallCnt != '1)
            stallCnt <= stallCnt + CNT_W'(1);
    end

    always_comb begin
        Occupancy = '0;
        for (int i = 0; i < STAGES; i++) Occupancy = Occupancy + OCC_W'(stageVld[i]);
`ifdef PIPE_SKID_BUFFER_EN
        Occupancy = Occupancy + OCC_W'(skidVld);
`endif
    end

    always_comb begin
        StageData = '0;
        for (int i = 0; i < STAGES; i++) StageData[i*DATA_W +: DATA_W] = stageReg[i];
    end

    assign StageValid = stageVld;
    assign StallCount = stallCnt;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Self-checking bench for pipe_ctrl_chain: vector table, directed hold/flush/reset sequences and
// randomized traffic against an order/occupancy scoreboard.
module tb_pipe_ctrl_chain;

    localparam int DATA_W = 32;
    localparam int STAGES = 5;
    localparam int CNT_W  = 16;
    localparam int LAST   = STAGES - 1;
    localparam int OCC_W  = $clog2(STAGES + 2);

    logic                     Clock;
    logic                     Reset;
    logic                     In_Valid;
    logic [DATA_W-1:0]        In_Data;
    logic                     In_Ready;
    logic                     Out_Valid;
    logic [DATA_W-1:0]        Out_Data;
    logic                     Out_Ready;
    logic [STAGES-1:0]        Hold;
    logic [STAGES-1:0]        Flush;
    logic [STAGES-1:0]        StageValid;
    logic [STAGES*DATA_W-1:0] StageData;
    logic [OCC_W-1:0]         Occupancy;
    logic [CNT_W-1:0]         StallCount;

    pipe_ctrl_chain #(.DATA_W(DATA_W), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .In_Valid(In_Valid), .In_Data(In_Data), .In_Ready(In_Ready),
        .Out_Valid(Out_Valid), .Out_Data(Out_Data), .Out_Ready(Out_Ready),
        .Hold(Hold), .Flush(Flush),
        .StageValid(StageValid), .StageData(StageData),
        .Occupancy(Occupancy), .StallCount(StallCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                step;
    } sbEntry_t;

    typedef struct {
        logic              inValid;
        logic [DATA_W-1:0] inData;
        logic              expInReady;
        logic              expOutValid;
        logic [DATA_W-1:0] expOutData;
        int                expOcc;
    } vec_t;

    int       checks = 0;
    int       fails = 0;
    int       stepNo = 0;
    int       popCount = 0;
    int       stallModel = 0;
    sbEntry_t sbQ[$];
    vec_t     vecs[16];

    task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] id, input logic ordy,
                                 input logic [STAGES-1:0] hold, input logic [STAGES-1:0] flush);
        @(negedge Clock);
        In_Valid  = iv;
        In_Data   = id;
        Out_Ready = ordy;
        Hold      = hold;
        Flush     = flush;
        #1;
    endtask

    // Scoreboard bookkeeping for the handshakes visible this cycle, then advance one edge.
    task automatic tick();
        if (Out_Valid && Out_Ready && !Hold[LAST]) begin
            if (sbQ.size() == 0) begin
                check("spuriousOut", Out_Valid, 1'b0);
            end else begin
                check("outData", Out_Data, sbQ[0].data);
                check("outLatency", (stepNo - sbQ[0].step) >= STAGES, 1'b1);
                void'(sbQ.pop_front());
                popCount++;
            end
        end
        if (In_Valid && In_Ready) sbQ.push_back('{In_Data, stepNo});
        if (In_Valid && !In_Ready && stallModel < (1 << CNT_W) - 1) stallModel++;
        @(posedge Clock);
        stepNo++;
    endtask

    task automatic sbKill(input logic [DATA_W-1:0] value);
        for (int i = 0; i < sbQ.size(); i++) begin
            if (sbQ[i].data == value) begin
                sbQ.delete(i);
                break;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, 1'b1, '0, '0);
            tick();
        end
    endtask

    task automatic doReset();
        @(negedge Clock);
        Reset     = 1'b0;
        In_Valid  = 1'b0;
        In_Data   = '0;
        Out_Ready = 1'b0;
        Hold      = '1;
        Flush     = '0;
        repeat (2) @(negedge Clock);
        #1;
        check("rstInReady", In_Ready, 1'b1);
        check("rstOutValid", Out_Valid, 1'b0);
        check("rstOutData", Out_Data, '0);
        check("rstStageValid", StageValid, '0);
        check("rstStageData", StageData, '0);
        check("rstOcc", Occupancy, '0);
        check("rstStall", StallCount, '0);
        @(negedge Clock);
        Reset = 1'b1;
        Hold  = '0;
        sbQ.delete();
        popCount   = 0;
        stallModel = 0;
    endtask

    task automatic checkOutput(input vec_t v, input int k);
        check($sformatf("vecInReady[%0d]", k), In_Ready, v.expInReady);
        check($sformatf("vecOutValid[%0d]", k), Out_Valid, v.expOutValid);
        if (v.expOutValid) check($sformatf("vecOutData[%0d]", k), Out_Data, v.expOutData);
        check($sformatf("vecOcc[%0d]", k), Occupancy, v.expOcc);
    endtask

    initial begin
        Reset = 1'b1; In_Valid = 1'b0; In_Data = '0; Out_Ready = 1'b0; Hold = '0; Flush = '0;

        // Stream 1..10: entry j is driven in step j-1, accepted on edge j, and shows at the output in step j+4.
        for (int k = 0; k < 16; k++) begin
            int accepted;
            int emitted;
            accepted = (k < 10) ? k : 10;
            emitted  = (k - 5 < 0) ? 0 : ((k - 5 > 10) ? 10 : k - 5);
            vecs[k].inValid     = (k < 10);
            vecs[k].inData      = (k < 10) ? DATA_W'(k + 1) : '0;
            vecs[k].expInReady  = 1'b1;
            vecs[k].expOutValid = (k >= 5) && (k <= 14);
            vecs[k].expOutData  = DATA_W'(k - 4);
            vecs[k].expOcc      = accepted - emitted;
        end
        doReset();
        for (int k = 0; k < 16; k++) begin
            applyStimulus(vecs[k].inValid, vecs[k].inData, 1'b1, '0, '0);
            checkOutput(vecs[k], k);
            tick();
        end
        check("streamPops", popCount, 10);
        check("streamStall", StallCount, '0);

        // Fill with the sink blocked, stall three cycles, then release.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, DATA_W'(32'h20 + k), 1'b0, '0, '0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, DATA_W'(32'h25), 1'b0, '0, '0);
            check("fullInReady", In_Ready, 1'b0);
            if (k == 0) check("fullOcc", Occupancy, STAGES);
            tick();
        end
        applyStimulus(1'b1, DATA_W'(32'h25), 1'b1, '0, '0);
        check("fullStall3", StallCount, 3);
        check("fullPassReady", In_Ready, 1'b1);
        tick();
        drain(10);
        check("fillPops", popCount, 6);
        check("fillEmpty", sbQ.size(), 0);

        // Hold stage 2 with the chain full: 0..2 freeze, stage 3 drains and leaves a bubble.
        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, DATA_W'(32'h30 + k), 1'b1, '0, '0);
            tick();
        end
        applyStimulus(1'b1, DATA_W'(32'h35), 1'b1, 5'b00100, '0);
        check("holdInReady", In_Ready, 1'b0);
        tick();
        applyStimulus(1'b1, DATA_W'(32'h35), 1'b1, 5'b00100, '0);
        check("holdValid1", StageValid, 5'b10111);
        check("holdData0", StageData[0*DATA_W +: DATA_W], 32'h34);
        check("holdData2", StageData[2*DATA_W +: DATA_W], 32'h32);
        check("holdData4", StageData[4*DATA_W +: DATA_W], 32'h31);
        tick();
        applyStimulus(1'b1, DATA_W'(32'h35), 1'b1, '0, '0);
        check("holdValid2", StageValid, 5'b00111);
        check("holdData1", StageData[1*DATA_W +: DATA_W], 32'h33);
        tick();
        drain(8);
        check("holdPops", popCount, 6);
        check("holdEmpty", sbQ.size(), 0);

        // Flush stage 1 while stage 0 moves into it, then kill stage 0 under simultaneous Hold+Flush.
        doReset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, DATA_W'(32'h40 + k), 1'b1, '0, '0);
            tick();
        end
        applyStimulus(1'b1, DATA_W'(32'h42), 1'b1, '0, 5'b00010);
        tick();
        sbKill(DATA_W'(32'h41));
        applyStimulus(1'b0, '0, 1'b1, 5'b00001, 5'b00001);
        check("flushValid", StageValid, 5'b00101);
        check("flushData0", StageData[0*DATA_W +: DATA_W], 32'h42);
        check("flushData1Kept", StageData[1*DATA_W +: DATA_W], 32'h40);
        tick();
        sbKill(DATA_W'(32'h42));
        applyStimulus(1'b0, '0, 1'b1, '0, '0);
        check("flushHoldValid", StageValid, 5'b01000);
        tick();
        drain(6);
        check("flushPops", popCount, 1);
        check("flushEmpty", sbQ.size(), 0);

        // Asynchronous reset with four entries in flight, then full latency for the next entry.
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, DATA_W'(32'h50 + k), 1'b1, '0, '0);
            tick();
        end
        applyStimulus(1'b0, '0, 1'b1, '0, '0);
        check("preResetOcc", Occupancy, 4);
        Reset = 1'b0;
        #1;
        check("midOutValid", Out_Valid, 1'b0);
        check("midOutData", Out_Data, '0);
        check("midStageValid", StageValid, '0);
        check("midStageData", StageData, '0);
        check("midOcc", Occupancy, '0);
        check("midInReady", In_Ready, 1'b1);
        @(negedge Clock);
        Reset = 1'b1;
        sbQ.delete();
        popCount   = 0;
        stallModel = 0;
        applyStimulus(1'b1, DATA_W'(32'h5A), 1'b1, '0, '0);
        tick();
        begin
            int  waitSteps;
            logic seen;
            waitSteps = 0;
            seen      = 1'b0;
            for (int n = 0; n < 20 && !seen; n++) begin
                applyStimulus(1'b0, '0, 1'b1, '0, '0);
                if (Out_Valid) seen = 1'b1;
                else waitSteps++;
                tick();
            end
            check("postResetSeen", seen, 1'b1);
            check("postResetLatency", waitSteps, STAGES - 1);
        end

        // Random traffic with random holds on the inner stages.
        doReset();
        for (int n = 0; n < 600; n++) begin
            logic [STAGES-1:0] hold;
            logic              ordy;
            hold = '0;
            for (int i = 0; i < LAST; i++) hold[i] = ($urandom_range(0, 7) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 3) != 0, DATA_W'($urandom), ordy, hold, '0);
            check("rndOcc", Occupancy, sbQ.size());
            if (sbQ.size() == 0) check("rndEmptyReady", In_Ready, 1'b1);
            if (sbQ.size() == STAGES && !ordy) check("rndFullReady", In_Ready, 1'b0);
            tick();
        end
        drain(12);
        check("rndEmpty", sbQ.size(), 0);
        check("rndStall", StallCount, stallModel);

        // Saturation of the stall counter.
        doReset();
        applyStimulus(1'b1, DATA_W'(32'h77), 1'b0, '0, '0);
        repeat (70000) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("stallSat", StallCount, 16'hFFFF);
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        #1;
        check("stallSatHold", StallCount, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
